// File: rtl/phase_to_wait_cnt.sv
// Measures the sigIn period in clk cycles and converts a phase fraction into a clamped wait count.
// Optional macro PHASE_WAIT_TIMEOUT_ZERO_EN: on timeout, also zero waitCnt and period.
module phase_to_wait_cnt #(
  parameter int WAIT_CNT_SIZE   = 11,
  parameter int PERIOD_CNT_SIZE = 12,
  parameter int PHASE_SIZE      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sigIn,
  input  logic [PHASE_SIZE-1:0]      phase,
  output logic [WAIT_CNT_SIZE-1:0]   waitCnt,
  output logic [PERIOD_CNT_SIZE-1:0] period,
  output logic                       periodValid
);

  localparam int PROD_W = PERIOD_CNT_SIZE + PHASE_SIZE;
  localparam logic [63:0] WAIT_ONES = (64'd1 << WAIT_CNT_SIZE) - 64'd1;
  localparam logic [63:0] CNT_ONES  = (64'd1 << PERIOD_CNT_SIZE) - 64'd1;
  localparam logic [PERIOD_CNT_SIZE-1:0] CNT_MAX  = '1;
  localparam logic [PERIOD_CNT_SIZE-1:0] WAIT_MAX =
    PERIOD_CNT_SIZE'((WAIT_ONES > CNT_ONES) ? CNT_ONES : WAIT_ONES);

  logic                       sync1, sync2, sync_prev;
  logic                       rise_pulse;
  logic [PERIOD_CNT_SIZE-1:0] counter;
  logic                       cnt_sat;
  logic                       armed;
  logic                       timeout;
  logic [PERIOD_CNT_SIZE-1:0] meas_reg;
  logic                       meas_valid;
  logic [PROD_W-1:0]          prod;
  logic [PERIOD_CNT_SIZE-1:0] lim;
  logic [PERIOD_CNT_SIZE-1:0] s1_period;
  logic                       s1_valid;
  logic [PERIOD_CNT_SIZE-1:0] raw;
  logic [PERIOD_CNT_SIZE-1:0] wait_next;

  assign rise_pulse = sync2 & ~sync_prev;
  assign cnt_sat    = (counter == CNT_MAX);
  // An edge coinciding with saturation takes priority: no timeout that cycle.
  assign timeout    = armed & cnt_sat & ~rise_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= sigIn;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      armed   <= 1'b0;
    end else begin
      if (rise_pulse)
        counter <= '0;
      else if (!cnt_sat)
        counter <= counter + 1'b1;

      if (rise_pulse)
        armed <= 1'b1;
      else if (timeout)
        armed <= 1'b0;
    end
  end

  // S0: capture the period; a saturated count is not a usable measurement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_reg   <= '0;
      meas_valid <= 1'b0;
    end else if (rise_pulse && armed && !cnt_sat) begin
      meas_reg   <= counter + 1'b1;
      meas_valid <= 1'b1;
    end else begin
      meas_valid <= 1'b0;
    end
  end

  // S1: scale by phase and compute the half-period ceiling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod      <= '0;
      lim       <= '0;
      s1_period <= '0;
      s1_valid  <= 1'b0;
    end else begin
      prod      <= PROD_W'(meas_reg) * PROD_W'(phase);
      lim       <= (meas_reg >= PERIOD_CNT_SIZE'(2)) ? (meas_reg >> 1) - 1'b1 : '0;
      s1_period <= meas_reg;
      s1_valid  <= meas_valid;
    end
  end

  assign raw = prod[PROD_W-1:PHASE_SIZE];

  always_comb begin
    wait_next = raw;
    if (lim < wait_next)
      wait_next = lim;
    if (WAIT_MAX < wait_next)
      wait_next = WAIT_MAX;
  end

  // S2: publish; outputs hold until the next measurement or a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt     <= '0;
      period      <= '0;
      periodValid <= 1'b0;
    end else if (s1_valid) begin
      waitCnt     <= WAIT_CNT_SIZE'(wait_next);
      period      <= s1_period;
      periodValid <= 1'b1;
    end else if (timeout) begin
      periodValid <= 1'b0;
`ifdef PHASE_WAIT_TIMEOUT_ZERO_EN
      waitCnt     <= '0;
      period      <= '0;
`else
      waitCnt     <= waitCnt;
      period      <= period;
`endif
    end
  end

endmodule
